lcd_spi_rx: RTL

- Receive-side counterpart of the LCD SPI write path: deserialises the 4-wire LCD bus (CS, DC, SCL, SDA) into 9-bit words {dc, byte}.
- Used as the in-fabric bus monitor for the LCD interface and as the receiver for a simulated LCD panel model.
- Word output uses a valid/ready handshake. Overrun and truncated-frame conditions are flagged.

---
 rtl/lcd_spi_rx.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/lcd_spi_rx.sv
// ============================================================================
// lcd_spi_rx : deserialises the 4-wire LCD SPI bus into {dc, byte} words
// Optional: define LCD_RX_FIFO_EN for a FIFO_DEPTH-entry output FIFO.
// Revision: 1.0
// ============================================================================
`default_nettype none

module lcd_spi_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int BITS        = 8,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          lcd_cs_i,
  input  logic          lcd_dc_i,
  input  logic          lcd_scl_i,
  input  logic          lcd_sda_i,
  output logic [BITS:0] data_o,
  output logic          valid_o,
  input  logic          ready_i,
  output logic          busy_o,
  output logic          overrun_o,
  output logic          frame_err_o,
  input  logic          ovr_clr_i
);

  localparam int CW = $clog2(BITS + 1);
  localparam logic [CW-1:0] C_LAST = CW'(BITS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] r_cs_sync, r_dc_sync, r_scl_sync, r_sda_sync;
  logic                   r_cs_hist, r_scl_hist;
  logic [SYNC_STAGES:0]   r_fill;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cs_sync  <= '1;
      r_dc_sync  <= '0;
      r_scl_sync <= '0;
      r_sda_sync <= '0;
      r_cs_hist  <= 1'b1;
      r_scl_hist <= 1'b0;
      r_fill     <= '0;
    end else begin
      r_cs_sync  <= {r_cs_sync[SYNC_STAGES-2:0], lcd_cs_i};
      r_dc_sync  <= {r_dc_sync[SYNC_STAGES-2:0], lcd_dc_i};
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], lcd_scl_i};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], lcd_sda_i};
      r_cs_hist  <= r_cs_sync[SYNC_STAGES-1];
      r_scl_hist <= r_scl_sync[SYNC_STAGES-1];
      r_fill     <= {r_fill[SYNC_STAGES-1:0], 1'b1};
    end
  end

  logic w_cs, w_dc, w_sda, w_scl_rise, w_cs_rise, w_cs_fall;
  assign w_cs       = r_cs_sync[SYNC_STAGES-1];
  assign w_dc       = r_dc_sync[SYNC_STAGES-1];
  assign w_sda      = r_sda_sync[SYNC_STAGES-1];
  assign w_scl_rise = r_scl_sync[SYNC_STAGES-1] & ~r_scl_hist;
  assign w_cs_rise  = w_cs & ~r_cs_hist;
  // A fall only counts once the history flop holds a real bus sample, so CS
  // held low across reset must go high and low again before a frame starts.
  assign w_cs_fall  = ~w_cs & r_cs_hist & r_fill[SYNC_STAGES];

  state_t          r_state;
  logic [BITS-1:0] r_shreg;
  logic [CW-1:0]   r_bit_cnt;
  logic            r_dc;
  logic            r_frame_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_shreg     <= '0;
      r_bit_cnt   <= '0;
      r_dc        <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_cs_fall) begin
            r_state   <= SHIFT;
            r_bit_cnt <= '0;
            r_shreg   <= '0;
          end
        end
        SHIFT: begin
          if (w_cs_rise) begin
            r_frame_err <= (r_bit_cnt != '0);
            r_bit_cnt   <= '0;
            r_state     <= IDLE;
          end else if (w_scl_rise) begin
            r_shreg   <= {r_shreg[BITS-2:0], w_sda};
            r_bit_cnt <= r_bit_cnt + 1'b1;
            if (r_bit_cnt == C_LAST) begin
              r_dc    <= w_dc;
              r_state <= COMMIT;
            end
          end
        end
        COMMIT: begin
          r_bit_cnt <= '0;
          r_state   <= w_cs ? IDLE : SHIFT;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  logic          w_commit, w_drop;
  logic [BITS:0] w_word;
  assign w_commit    = (r_state == COMMIT);
  assign w_word      = {r_dc, r_shreg};
  assign busy_o      = (r_state != IDLE);
  assign frame_err_o = r_frame_err;

`ifdef LCD_RX_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [BITS:0] r_mem [FIFO_DEPTH];
  logic [AW:0]   r_wr_ptr, r_rd_ptr;
  logic          w_empty, w_full, w_pop, w_push;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop   = ~w_empty & ready_i;
  assign w_push  = w_commit & (~w_full | w_pop);
  assign w_drop  = w_commit & w_full & ~w_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr[AW-1:0]] <= w_word;
        r_wr_ptr                <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  assign data_o  = r_mem[r_rd_ptr[AW-1:0]];
  assign valid_o = ~w_empty;
`else
  logic [BITS:0] r_data;
  logic          r_valid, w_pop;

  assign w_pop  = r_valid & ready_i;
  assign w_drop = w_commit & r_valid & ~w_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (w_commit && (!r_valid || w_pop)) begin
      r_data  <= w_word;
      r_valid <= 1'b1;
    end else if (w_pop) begin
      r_valid <= 1'b0;
    end
  end

  assign data_o  = r_data;
  assign valid_o = r_valid;
`endif

  logic r_overrun;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_overrun <= 1'b0;
    else if (w_drop)    r_overrun <= 1'b1;
    else if (ovr_clr_i) r_overrun <= 1'b0;
  end

  assign overrun_o = r_overrun;

endmodule

`default_nettype wire
